// File: rtl/stack_call_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : stack_call_sequencer_if
// Description : Bundles the ICU request side, the subroutine-stack side and
//               the PC-load side of the call/return sequencer.
//               master : ICU decode + stack instance (drives requests and
//                        stack status, observes strobes)
//               slave  : the sequencer itself
// Ports       : call_req/ret_req/call_target/pc_in/err_clear  (ICU -> seq)
//               stack_full/stack_empty/stack_top             (stack -> seq)
//               stack_instruction/stack_execute/stack_wdata  (seq -> stack)
//               pc_load/pc_load_value                        (seq -> PC)
//               busy/depth/overflow_err/underflow_err        (seq -> ICU)
// Revision    : 1.0  initial release
// ============================================================================
interface stack_call_sequencer_if #(
  parameter int WORD     = 4,
  parameter int SIZE_LOG = 4
);
  logic                call_req;
  logic                ret_req;
  logic [WORD-1:0]     call_target;
  logic [WORD-1:0]     pc_in;
  logic                err_clear;
  logic                stack_full;
  logic                stack_empty;
  logic [WORD-1:0]     stack_top;
  logic [1:0]          stack_instruction;
  logic                stack_execute;
  logic [WORD-1:0]     stack_wdata;
  logic                pc_load;
  logic [WORD-1:0]     pc_load_value;
  logic                busy;
  logic [SIZE_LOG:0]   depth;
  logic                overflow_err;
  logic                underflow_err;

  modport master (
    output call_req, ret_req, call_target, pc_in, err_clear,
           stack_full, stack_empty, stack_top,
    input  stack_instruction, stack_execute, stack_wdata,
           pc_load, pc_load_value, busy, depth, overflow_err, underflow_err
  );

  modport slave (
    input  call_req, ret_req, call_target, pc_in, err_clear,
           stack_full, stack_empty, stack_top,
    output stack_instruction, stack_execute, stack_wdata,
           pc_load, pc_load_value, busy, depth, overflow_err, underflow_err
  );
endinterface
`default_nettype wire

// File: rtl/stack_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stack_call_sequencer
// Description : Sequences a subroutine stack for call/return. A call pushes
//               PC+1 then loads the call target into the PC; a return pops
//               the stack then loads the popped address into the PC. Tracks
//               call depth and raises sticky overflow/underflow flags.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-high
//               bus   - stack_call_sequencer_if.slave (requests, stack
//                       handshake, PC load, status)
// Revision    : 1.0  initial release
// ============================================================================
module stack_call_sequencer #(
  parameter int WORD     = 4,
  parameter int SIZE_LOG = 4
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  stack_call_sequencer_if.slave     bus
);

  localparam int unsigned       C_SIZE      = 1 << SIZE_LOG;
  localparam logic [SIZE_LOG:0] C_DEPTH_MAX = (SIZE_LOG+1)'(C_SIZE);
  localparam logic [1:0]        C_OP_IDLE   = 2'b00;
  localparam logic [1:0]        C_OP_PUSH   = 2'b01;
  localparam logic [1:0]        C_OP_POP    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2,
    ST_LOAD = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD-1:0]     target_q, target_d;
  logic [WORD-1:0]     ret_q, ret_d;
  logic [WORD-1:0]     pcv_q, pcv_d;
  logic [SIZE_LOG:0]   depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                w_ovf_set;
  logic                w_unf_set;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      ret_q    <= '0;
      pcv_q    <= '0;
      depth_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      ret_q    <= ret_d;
      pcv_q    <= pcv_d;
      depth_q  <= depth_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    ret_d     = ret_q;
    pcv_d     = pcv_q;
    depth_d   = depth_q;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Requests are only looked at here; while busy they are dropped.
        if (bus.call_req && bus.ret_req) begin
          w_ovf_set = 1'b1;
          w_unf_set = 1'b1;
        end else if (bus.call_req) begin
          if (bus.stack_full) begin
            w_ovf_set = 1'b1;
          end else begin
            target_d = bus.call_target;
            ret_d    = bus.pc_in + WORD'(1);
            state_d  = ST_PUSH;
          end
        end else if (bus.ret_req) begin
          if (bus.stack_empty) begin
            w_unf_set = 1'b1;
          end else begin
            state_d = ST_POP;
          end
        end
      end

      ST_PUSH: begin
        if (depth_q != C_DEPTH_MAX) begin
          depth_d = depth_q + 1'b1;
        end
        // Load value is staged into its own register so it holds after LOAD.
        pcv_d   = target_q;
        state_d = ST_LOAD;
      end

      ST_POP: begin
        if (depth_q != '0) begin
          depth_d = depth_q - 1'b1;
        end
        // Top-of-stack is still the pre-pop value on this edge.
        target_d = bus.stack_top;
        pcv_d    = bus.stack_top;
        state_d  = ST_LOAD;
      end

      ST_LOAD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky flags: a new error in the same cycle as err_clear wins.
    ovf_d = w_ovf_set | (ovf_q & ~bus.err_clear);
    unf_d = w_unf_set | (unf_q & ~bus.err_clear);
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state
  // --------------------------------------------------------------------------
  always_comb begin
    bus.stack_instruction = C_OP_IDLE;
    if (state_q == ST_PUSH) begin
      bus.stack_instruction = C_OP_PUSH;
    end else if (state_q == ST_POP) begin
      bus.stack_instruction = C_OP_POP;
    end
  end

  assign bus.stack_execute = (state_q == ST_PUSH) || (state_q == ST_POP);
  assign bus.stack_wdata   = ret_q;
  assign bus.pc_load       = (state_q == ST_LOAD);
  assign bus.pc_load_value = pcv_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.depth         = depth_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_stack_call_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_call_sequencer
// Description : Self-checking bench for stack_call_sequencer: directed
//               vector table, hand-written multi-cycle sequences, and a
//               randomized run against a transaction-level reference model
//               that also stands in for the attached stack.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stack_call_sequencer;

  localparam int W    = 4;
  localparam int SL   = 2;
  localparam int SIZE = 1 << SL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_call_sequencer_if #(.WORD(W), .SIZE_LOG(SL)) bus ();

  stack_call_sequencer #(.WORD(W), .SIZE_LOG(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit c, input bit r, input logic [W-1:0] t,
                       input logic [W-1:0] pc, input bit f, input bit e,
                       input logic [W-1:0] top, input bit clr);
    bus.call_req    = c;
    bus.ret_req     = r;
    bus.call_target = t;
    bus.pc_in       = pc;
    bus.stack_full  = f;
    bus.stack_empty = e;
    bus.stack_top   = top;
    bus.err_clear   = clr;
  endtask

  task automatic do_reset();
    drive(0, 0, '0, '0, 0, 1, '0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    bit         call;
    bit         ret;
    logic [3:0] tgt;
    logic [3:0] pc;
    bit         full;
    bit         empty;
    logic [3:0] top;
    bit         exp_op;
    logic [1:0] exp_instr;
    logic [3:0] exp_wdata;
    logic [3:0] exp_pcv;
    int         exp_depth;
    bit         exp_ovf;
    bit         exp_unf;
  } vec_t;

  vec_t vecs[8];

  // ---------------------------------------------------------------- model
  typedef struct {
    bit         exec;
    logic [1:0] instr;
    logic [3:0] wdata;
    bit         pcl;
    logic [3:0] pcv;
  } ev_t;

  ev_t        sched[$];
  logic [3:0] m_stk[$];
  bit         m_ovf, m_unf;
  logic [3:0] m_pcv;

  function automatic void model_reset();
    sched.delete();
    m_stk.delete();
    m_ovf = 0;
    m_unf = 0;
    m_pcv = '0;
  endfunction

  task automatic model_check();
    ev_t e;
    bit  bsy;
    e   = '{exec: 0, instr: 2'b00, wdata: 4'h0, pcl: 0, pcv: 4'h0};
    bsy = (sched.size() != 0);
    if (bsy) e = sched[0];
    chk("rnd_busy", int'(bus.busy), int'(bsy));
    chk("rnd_exec", int'(bus.stack_execute), int'(e.exec));
    chk("rnd_instr", int'(bus.stack_instruction), int'(e.instr));
    if (e.instr == 2'b01) chk("rnd_wdata", int'(bus.stack_wdata), int'(e.wdata));
    chk("rnd_pcload", int'(bus.pc_load), int'(e.pcl));
    chk("rnd_pcval", int'(bus.pc_load_value), e.pcl ? int'(e.pcv) : int'(m_pcv));
    chk("rnd_depth", int'(bus.depth), m_stk.size());
    chk("rnd_ovf", int'(bus.overflow_err), int'(m_ovf));
    chk("rnd_unf", int'(bus.underflow_err), int'(m_unf));
  endtask

  function automatic void model_step(input bit c, input bit r, input logic [3:0] t,
                                     input logic [3:0] pc, input bit f, input bit e,
                                     input logic [3:0] top, input bit clr);
    bit         os, us;
    ev_t        ev;
    logic [3:0] nx;
    os = 0;
    us = 0;
    if (sched.size() != 0) begin
      ev = sched.pop_front();
      if (ev.instr == 2'b01) m_stk.push_back(ev.wdata);
      if (ev.instr == 2'b10) void'(m_stk.pop_back());
      if (ev.pcl) m_pcv = ev.pcv;
    end else if (c && r) begin
      os = 1;
      us = 1;
    end else if (c) begin
      if (f) os = 1;
      else begin
        nx = pc + 4'd1;
        sched.push_back('{exec: 1, instr: 2'b01, wdata: nx, pcl: 0, pcv: 4'h0});
        sched.push_back('{exec: 0, instr: 2'b00, wdata: 4'h0, pcl: 1, pcv: t});
      end
    end else if (r) begin
      if (e) us = 1;
      else begin
        sched.push_back('{exec: 1, instr: 2'b10, wdata: 4'h0, pcl: 0, pcv: 4'h0});
        sched.push_back('{exec: 0, instr: 2'b00, wdata: 4'h0, pcl: 1, pcv: top});
      end
    end
    m_ovf = os | (m_ovf & !clr);
    m_unf = us | (m_unf & !clr);
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    vec_t v;
    bit c, r, f, e, clr;
    logic [3:0] t, pc, top;
    int rv;

    vecs[0] = '{1, 0, 4'hA, 4'h3, 0, 0, 4'h0, 1, 2'b01, 4'h4, 4'hA, 1, 0, 0};
    vecs[1] = '{1, 0, 4'h5, 4'hF, 0, 0, 4'h0, 1, 2'b01, 4'h0, 4'h5, 1, 0, 0};
    vecs[2] = '{0, 1, 4'h0, 4'h0, 0, 0, 4'h4, 1, 2'b10, 4'h0, 4'h4, 0, 0, 0};
    vecs[3] = '{1, 0, 4'h7, 4'h2, 1, 0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0, 1, 0};
    vecs[4] = '{0, 1, 4'h0, 4'h0, 0, 1, 4'h9, 0, 2'b00, 4'h0, 4'h0, 0, 0, 1};
    vecs[5] = '{1, 1, 4'h3, 4'h3, 0, 0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0, 1, 1};
    vecs[6] = '{1, 1, 4'h3, 4'h3, 1, 1, 4'h0, 0, 2'b00, 4'h0, 4'h0, 0, 1, 1};
    vecs[7] = '{1, 0, 4'h0, 4'hE, 0, 0, 4'h0, 1, 2'b01, 4'hF, 4'h0, 1, 0, 0};

    reset = 1'b1;
    drive(0, 0, '0, '0, 0, 1, '0, 0);
    tick();
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_instr", int'(bus.stack_instruction), 0);
    chk("rst_depth", int'(bus.depth), 0);
    chk("rst_errs", int'({bus.overflow_err, bus.underflow_err}), 0);
    chk("rst_pcv", int'(bus.pc_load_value), 0);
    reset = 1'b0;

    // ---- table vectors: one request from a freshly reset sequencer
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      do_reset();
      drive(v.call, v.ret, v.tgt, v.pc, v.full, v.empty, v.top, 0);
      tick();                                        // N+1
      drive(0, 0, v.tgt, v.pc, v.full, v.empty, v.top, 0);
      chk($sformatf("vec%0d_busy1", i), int'(bus.busy), int'(v.exp_op));
      chk($sformatf("vec%0d_exec", i), int'(bus.stack_execute), int'(v.exp_op));
      chk($sformatf("vec%0d_instr", i), int'(bus.stack_instruction), int'(v.exp_instr));
      if (v.exp_instr == 2'b01)
        chk($sformatf("vec%0d_wdata", i), int'(bus.stack_wdata), int'(v.exp_wdata));
      chk($sformatf("vec%0d_pcl1", i), int'(bus.pc_load), 0);
      tick();                                        // N+2
      chk($sformatf("vec%0d_pcl2", i), int'(bus.pc_load), int'(v.exp_op));
      chk($sformatf("vec%0d_exec2", i), int'(bus.stack_execute), 0);
      chk($sformatf("vec%0d_pcv", i), int'(bus.pc_load_value), int'(v.exp_pcv));
      tick();                                        // N+3
      chk($sformatf("vec%0d_busy3", i), int'(bus.busy), 0);
      chk($sformatf("vec%0d_pcvhold", i), int'(bus.pc_load_value), int'(v.exp_pcv));
      chk($sformatf("vec%0d_depth", i), int'(bus.depth), v.exp_depth);
      chk($sformatf("vec%0d_ovf", i), int'(bus.overflow_err), int'(v.exp_ovf));
      chk($sformatf("vec%0d_unf", i), int'(bus.underflow_err), int'(v.exp_unf));
    end

    // ---- call, held request while busy, return, then reset during PUSH
    do_reset();
    drive(1, 0, 4'hA, 4'h3, 0, 1, 4'h0, 0);
    tick();                                          // PUSH, call still held
    chk("seq_push_exec", int'(bus.stack_execute), 1);
    chk("seq_push_wdata", int'(bus.stack_wdata), 4);
    tick();                                          // LOAD
    drive(0, 0, 4'h0, 4'h0, 0, 0, 4'h4, 0);
    chk("seq_load_exec", int'(bus.stack_execute), 0);
    chk("seq_load_val", int'(bus.pc_load_value), 10);
    tick();                                          // IDLE: one push only
    chk("seq_idle_busy", int'(bus.busy), 0);
    chk("seq_one_push", int'(bus.depth), 1);
    drive(0, 1, 4'h0, 4'h0, 0, 0, 4'h4, 0);
    tick();                                          // POP
    drive(0, 0, 4'h0, 4'h0, 0, 0, 4'h4, 0);
    chk("seq_pop_instr", int'(bus.stack_instruction), 2);
    tick();                                          // LOAD
    chk("seq_pop_pcl", int'(bus.pc_load), 1);
    chk("seq_pop_val", int'(bus.pc_load_value), 4);
    tick();
    chk("seq_pop_depth", int'(bus.depth), 0);
    drive(1, 0, 4'h6, 4'h1, 0, 1, 4'h0, 0);
    tick();                                          // PUSH
    drive(0, 0, 4'h0, 4'h0, 0, 1, 4'h0, 0);
    chk("seq_push2_exec", int'(bus.stack_execute), 1);
    #2 reset = 1'b1;
    #1;
    chk("seq_rst_busy", int'(bus.busy), 0);
    chk("seq_rst_exec", int'(bus.stack_execute), 0);
    chk("seq_rst_depth", int'(bus.depth), 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("seq_rst_nopcl", int'(bus.pc_load), 0);
      tick();
    end

    // ---- sticky flags, clear, and set-wins-over-clear
    do_reset();
    drive(1, 0, 4'h1, 4'h1, 1, 0, 4'h0, 0);
    tick();
    drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0);
    chk("err_ovf_set", int'(bus.overflow_err), 1);
    chk("err_ovf_nobusy", int'(bus.busy), 0);
    tick();
    chk("err_ovf_sticky", int'(bus.overflow_err), 1);
    chk("err_ovf_nopcl", int'(bus.pc_load), 0);
    drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 1);
    tick();
    chk("err_ovf_clr", int'(bus.overflow_err), 0);
    drive(1, 0, 4'h1, 4'h1, 1, 0, 4'h0, 1);
    tick();
    drive(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 0);
    chk("err_set_wins", int'(bus.overflow_err), 1);
    chk("err_unf_clean", int'(bus.underflow_err), 0);

    // ---- randomized run against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      model_check();
      rv  = int'($urandom_range(0, 99));
      c   = (rv < 35) || (rv >= 97);
      r   = (rv >= 35 && rv < 70) || (rv >= 97);
      clr = ($urandom_range(0, 15) == 0);
      t   = 4'($urandom);
      pc  = 4'($urandom);
      f   = (m_stk.size() == SIZE);
      e   = (m_stk.size() == 0);
      top = (m_stk.size() != 0) ? m_stk[m_stk.size()-1] : 4'($urandom);
      drive(c, r, t, pc, f, e, top, clr);
      model_step(c, r, t, pc, f, e, top, clr);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_call_sequencer.md
Name: stack_call_sequencer

Overview:
- Controller that sequences the PS34706 subroutine stack for the ICU's call/return flow.
- Accepts single-cycle call/return requests from the ICU control decode and issues the stack's instruction/execute strobes.
- Computes return address (PC+1), then drives the program-counter load with the call target or the popped address.
- Stalls the ICU via busy, tracks call depth, and flags overflow/underflow.

Parameters:
- WORD, 4, address/stack word width in bits.
- SIZE_LOG, 4, log2 of stack depth; must match the attached stack instance.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- call_req  input  1  call request, sampled only while busy=0.
- ret_req  input  1  return request, sampled only while busy=0.
- call_target  input  WORD  subroutine entry address, sampled with call_req.
- pc_in  input  WORD  current program counter, sampled with call_req.
- err_clear  input  1  clears sticky error flags.
- stack_full  input  1  stack full indication.
- stack_empty  input  1  stack empty indication.
- stack_top  input  WORD  current top-of-stack value from the stack.
- stack_instruction  output  2  stack operation: 2'b01 push, 2'b10 pop, 2'b00 idle.
- stack_execute  output  1  one-cycle execute strobe to the stack.
- stack_wdata  output  WORD  value to push.
- pc_load  output  1  one-cycle PC load strobe.
- pc_load_value  output  WORD  value loaded into the PC.
- busy  output  1  sequencer not in IDLE; ICU must hold.
- depth  output  SIZE_LOG+1  current call depth, 0..SIZE.
- overflow_err  output  1  sticky: call rejected because the stack was full.
- underflow_err  output  1  sticky: return rejected because the stack was empty.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0: stack_instruction=00, depth=0, errors=0, registered target/data=0.
- FSM states: IDLE, PUSH, POP, LOAD. busy = (state != IDLE), decoded from the registered state.
- IDLE, call_req=1 and ret_req=0:
  - If stack_full=0: latch target=call_target and ret=pc_in+1 (mod 2^WORD; 0xF+1 -> 0x0). Go to PUSH.
  - If stack_full=1: set overflow_err, stay in IDLE, no stack or PC activity.
- IDLE, ret_req=1 and call_req=0:
  - If stack_empty=0: go to POP.
  - If stack_empty=1: set underflow_err, stay in IDLE.
- IDLE, call_req and ret_req both 1: illegal. Set both error flags, no operation.
- PUSH (1 cycle): stack_execute=1, stack_instruction=01, stack_wdata=ret. depth increments at the cycle end. Go to LOAD with pc_load_value source = target.
- POP (1 cycle): stack_execute=1, stack_instruction=10. Capture stack_top into target on the same edge. depth decrements. Go to LOAD.
- LOAD (1 cycle): pc_load=1, pc_load_value=target. Go to IDLE.
- Latency: request cycle N -> stack strobe in cycle N+1 -> pc_load in cycle N+2 -> busy=0 again in cycle N+3. The next request is accepted in cycle N+3.
- Requests while busy=1 are ignored; they are neither queued nor flagged.
- Outside PUSH/POP: stack_execute=0, stack_instruction=00. Outside LOAD: pc_load=0. pc_load_value holds its last value.
- depth saturates at SIZE and at 0. It never wraps; the full/empty checks guarantee this in legal use.
- Error flags are sticky until err_clear=1. If err_clear and a new error occur in the same cycle, set wins.
- Reset asserted mid-sequence (PUSH/POP/LOAD): immediate return to IDLE. No pc_load is issued. depth=0; the stack instance is reset by the same signal.

Test Plan:
- Reset, then call_req with pc_in=0x3, call_target=0xA -> cycle+1: execute=1, instr=01, wdata=0x4. Cycle+2: pc_load=1, value=0xA. depth=1, busy high for 2 cycles.
- After the above, ret_req with stack_top=0x4 -> cycle+1: execute=1, instr=10. Cycle+2: pc_load=1, value=0x4. depth=0.
- call_req with pc_in=0xF -> wdata=0x0 (wrap-around).
- call_req with stack_full=1 -> overflow_err=1, no execute, no pc_load. err_clear=1 -> overflow_err=0 next cycle.
- ret_req with stack_empty=1 -> underflow_err=1. Simultaneous call_req+ret_req -> both errors set, FSM stays IDLE.
- Assert reset during PUSH -> next edge/async: busy=0, pc_load never pulses, depth=0. call_req during busy is ignored (exactly one push observed).
